// File: rtl/convert_3x32_to_48.sv
// ---------------------------------------------------------------------------
// convert_3x32_to_48
//
// Purpose:
//   Packs the low 16 bits of three consecutive input words into one 48-bit
//   output word. Input words are buffered in a small FIFO. An output write
//   is issued only when the downstream side is not full.
//
// Ports:
//   clk            in   the only clock
//   rst_n          in   asynchronous active-low reset
//   wen_32         in   input word write strobe
//   wdata_32       in   input word; bits 15:0 carry payload
//   error_full_32  out  input FIFO full; writes are rejected while high
//   error_full_48  in   downstream full; holds off wen_48
//   wen_48         out  one-cycle output write strobe
//   wdata_48       out  packed output word: lane0 in [15:0], lane2 in [47:32]
//   error_overflow out  sticky: a write arrived while the FIFO was full
//   error_upper    out  sticky: a popped word had nonzero bits 31:16
//
// Optional feature:
//   Define CONVERT_3X32_TO_48_UPPER_CHECK_EN to enable the upper-half check.
//   When it is not defined, error_upper is tied to 0.
// ---------------------------------------------------------------------------
module convert_3x32_to_48 #(
  parameter int AXI_DATA_WIDTH             = 32,
  parameter int BYTE_WIDTH                 = 8,
  parameter int CSA_OUT_DATA_WIDTH_BY_BYTE = 6,
  parameter int CSA_OUT_OUT_DATA_WIDTH     = BYTE_WIDTH * CSA_OUT_DATA_WIDTH_BY_BYTE,
  parameter int FIFO_DEPTH                 = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wen_32,
  input  logic [AXI_DATA_WIDTH-1:0]         wdata_32,
  output logic                              error_full_32,
  input  logic                              error_full_48,
  output logic                              wen_48,
  output logic [CSA_OUT_OUT_DATA_WIDTH-1:0] wdata_48,
  output logic                              error_overflow,
  output logic                              error_upper
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_OUT     = 1'b1
  } state_t;

  // FIFO storage and pointers. The extra pointer MSB separates full from empty.
  logic [AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]            r_wptr;
  logic [PTR_W:0]            r_rptr;
  logic [PTR_W:0]            w_count;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic [AXI_DATA_WIDTH-1:0] w_rdata;

  // Packing state
  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [1:0]                        r_lane;
  logic [1:0]                        w_lane_nxt;
  logic [CSA_OUT_OUT_DATA_WIDTH-1:0] r_wdata;
  logic [CSA_OUT_OUT_DATA_WIDTH-1:0] w_wdata_nxt;
  logic                              r_wen;
  logic                              w_wen_nxt;
  logic                              r_overflow;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == FULL_CNT);
  assign w_empty = (r_wptr == r_rptr);
  // The full flag comes only from registered pointers. A pop in the same
  // cycle does not free a slot for this cycle's write.
  assign w_push  = wen_32 & ~w_full;
  assign w_rdata = r_mem[r_rptr[PTR_W-1:0]];

  // FIFO storage write port (no reset needed; pointers define validity)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= wdata_32;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= {(PTR_W + 1){1'b0}};
      r_rptr     <= {(PTR_W + 1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (PTR_W + 1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W + 1)'(1);
      end
      if (wen_32 && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state, lane packing and output strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_wdata_nxt = r_wdata;
    w_wen_nxt   = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (r_lane)
            2'd0: begin
              w_wdata_nxt[15:0] = w_rdata[15:0];
              w_lane_nxt        = 2'd1;
            end
            2'd1: begin
              w_wdata_nxt[31:16] = w_rdata[15:0];
              w_lane_nxt         = 2'd2;
            end
            2'd2: begin
              w_wdata_nxt[47:32] = w_rdata[15:0];
              w_lane_nxt         = 2'd0;
              w_state_nxt        = ST_OUT;
            end
            default: begin
              w_lane_nxt = 2'd0;
            end
          endcase
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_OUT: begin
        // No pop in this state. wdata_48 stays stable while downstream is full.
        if (!error_full_48) begin
          w_wen_nxt   = 1'b1;
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_lane_nxt  = 2'd0;
      end
    endcase
  end

  // Packing state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_COLLECT;
      r_lane  <= 2'd0;
      r_wdata <= {CSA_OUT_OUT_DATA_WIDTH{1'b0}};
      r_wen   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_wdata <= w_wdata_nxt;
      r_wen   <= w_wen_nxt;
    end
  end

`ifdef CONVERT_3X32_TO_48_UPPER_CHECK_EN
  logic r_upper;

  // Sticky flag for popped words whose upper half is nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upper <= 1'b0;
    end else begin
      if (w_pop && (|w_rdata[AXI_DATA_WIDTH-1:16])) begin
        r_upper <= 1'b1;
      end
    end
  end

  assign error_upper = r_upper;
`else
  // The upper half is deliberately ignored in this build.
  logic w_unused_upper;
  assign w_unused_upper = ^w_rdata[AXI_DATA_WIDTH-1:16];
  assign error_upper    = 1'b0;
`endif

  assign error_full_32  = w_full;
  assign wen_48         = r_wen;
  assign wdata_48       = r_wdata;
  assign error_overflow = r_overflow;

endmodule

// File: tb/tb_convert_3x32_to_48.sv
// ---------------------------------------------------------------------------
// tb_convert_3x32_to_48
//
// Directed and random stimulus for convert_3x32_to_48. Accepted input words
// are grouped in threes into expected 48-bit words and queued. A monitor
// compares each wen_48 pulse against the head of that queue.
// Defining CONVERT_3X32_TO_48_UPPER_CHECK_EN changes the expected error_upper.
// ---------------------------------------------------------------------------
module tb_convert_3x32_to_48;

  logic        clk;
  logic        rst_n;
  logic        wen_32;
  logic [31:0] wdata_32;
  logic        error_full_32;
  logic        error_full_48;
  logic        wen_48;
  logic [47:0] wdata_48;
  logic        error_overflow;
  logic        error_upper;

  int errors = 0;
  int checks = 0;

  logic [15:0] part_q[$];
  logic [47:0] exp_q[$];
  logic        prev_wen = 1'b0;

  convert_3x32_to_48 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wen_32         (wen_32),
    .wdata_32       (wdata_32),
    .error_full_32  (error_full_32),
    .error_full_48  (error_full_48),
    .wen_48         (wen_48),
    .wdata_48       (wdata_48),
    .error_overflow (error_overflow),
    .error_upper    (error_upper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: every three accepted payloads form one expected output.
  task automatic model_push(input logic [15:0] w);
    part_q.push_back(w);
    if (part_q.size() == 3) begin
      exp_q.push_back({part_q[2], part_q[1], part_q[0]});
      part_q.delete();
    end
  endtask

  // Present one word for one edge. acc tells the model whether it is accepted.
  task automatic wr(input logic [31:0] d, input bit acc);
    wen_32   = 1'b1;
    wdata_32 = d;
    @(posedge clk);
    #1;
    wen_32 = 1'b0;
    if (acc) model_push(d[15:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    part_q.delete();
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    idle(2);
  endtask

  // Output monitor: compares each output pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wen_48) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got=%h exp=none", wdata_48);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if (wdata_48 !== e) begin
            errors++;
            $display("FAIL out_data got=%h exp=%h", wdata_48, e);
          end
        end
        check("wen_single_cycle", 64'(prev_wen), 64'd0);
      end
      prev_wen = wen_48;
    end else begin
      prev_wen = 1'b0;
    end
  end

  initial begin
    int pulses;
    int acc;
    int iter;
    logic [31:0] rw;

    rst_n         = 1'b0;
    wen_32        = 1'b0;
    wdata_32      = 32'd0;
    error_full_48 = 1'b0;
    #12;
    check("rst_wen48", 64'(wen_48), 64'd0);
    check("rst_wdata48", 64'(wdata_48), 64'd0);
    check("rst_overflow", 64'(error_overflow), 64'd0);
    check("rst_upper", 64'(error_upper), 64'd0);
    check("rst_full32", 64'(error_full_32), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Basic frame and latency: output two edges after the third write.
    wr(32'h1111, 1'b1);
    wr(32'h2222, 1'b1);
    wr(32'h3333, 1'b1);
    check("lat_e3_wen", 64'(wen_48), 64'd0);
    idle(1);
    check("lat_e4_wen", 64'(wen_48), 64'd0);
    idle(1);
    check("lat_e5_wen", 64'(wen_48), 64'd1);
    check("lat_e5_data", 64'(wdata_48), 64'h333322221111);
    idle(1);
    check("lat_e6_wen", 64'(wen_48), 64'd0);
    wait_drain("drain_basic", 20);

    // Downstream back-pressure: hold for ten cycles, then release once.
    error_full_48 = 1'b1;
    wr(32'h4444, 1'b1);
    wr(32'h5555, 1'b1);
    wr(32'h6666, 1'b1);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("hold_wen", 64'(wen_48), 64'd0);
      check("hold_data", 64'(wdata_48), 64'h666655554444);
    end
    error_full_48 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (wen_48) pulses++;
    end
    check("release_pulses", 64'(pulses), 64'd1);
    wait_drain("drain_hold", 20);

    // Fill the FIFO while stalled: 3 words sit in lanes, 8 in the FIFO, 12th dropped.
    pulse_reset();
    error_full_48 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      wr(32'(k), (k != 12));
      check("ovf_full32", 64'(error_full_32), (k >= 11) ? 64'd1 : 64'd0);
      check("ovf_flag", 64'(error_overflow), (k == 12) ? 64'd1 : 64'd0);
      check("ovf_wen_held", 64'(wen_48), 64'd0);
    end
    error_full_48 = 1'b0;
    idle(15);
    check("ovf_full32_clear", 64'(error_full_32), 64'd0);
    check("ovf_sticky", 64'(error_overflow), 64'd1);
    // Words 10 and 11 wait in the lanes; word 13 completes 0x000D000B000A.
    wr(32'hD, 1'b1);
    wait_drain("drain_ovf", 60);

    // Reset mid-frame drops partial lanes.
    wr(32'h5, 1'b1);
    wr(32'h6, 1'b1);
    pulse_reset();
    check("midrst_overflow", 64'(error_overflow), 64'd0);
    check("midrst_data", 64'(wdata_48), 64'd0);
    wr(32'hA, 1'b1);
    wr(32'hB, 1'b1);
    wr(32'hC, 1'b1);
    wait_drain("drain_midrst", 20);

    // Upper half check; the data path uses only the low half.
    wr(32'h0001_0005, 1'b1);
    idle(2);
`ifdef CONVERT_3X32_TO_48_UPPER_CHECK_EN
    check("upper_flag", 64'(error_upper), 64'd1);
`else
    check("upper_flag", 64'(error_upper), 64'd0);
`endif
    wr(32'h6, 1'b1);
    wr(32'h7, 1'b1);
    wait_drain("drain_upper", 20);

    // Random traffic that respects error_full_32, with random back-pressure.
    pulse_reset();
    acc  = 0;
    iter = 0;
    while (acc < 999 && iter < 20000) begin
      error_full_48 = ($urandom_range(0, 3) == 0);
      if (!error_full_32 && ($urandom_range(0, 9) < 7)) begin
        rw = $urandom;
        wr(rw, 1'b1);
        acc++;
      end else begin
        idle(1);
      end
      iter++;
    end
    check("rand_all_written", 64'(acc), 64'd999);
    error_full_48 = 1'b0;
    wait_drain("drain_random", 2000);
    check("rand_overflow", 64'(error_overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
